// File: rtl/panda_pkg.sv
// Shared types for the Panda pipeline: EX/MEM and MEM/WB bundles plus LSU enums.
package panda_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE,
    LSU_HALF,
    LSU_WORD
  } lsu_width_e;

  typedef enum logic [1:0] {
    RD_DATA_ALU,
    RD_DATA_PC_INC,
    RD_DATA_IMM,
    RD_DATA_MEM
  } rd_data_sel_e;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_WAIT_GNT,
    LSU_WAIT_RVALID
  } lsu_state_e;

  typedef struct packed {
    logic [31:0]  alu_result;
    logic [31:0]  pc_inc;
    logic [31:0]  imm;
    logic [31:0]  rs2_data;
    logic [4:0]   rs2_addr;
    logic [4:0]   rd_addr;
    logic         rd_we;
    rd_data_sel_e rd_data_sel;
    logic         lsu_store;
    lsu_width_e   lsu_width;
    logic         lsu_load_unsigned;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] rd_data;
    logic [4:0]  rd_addr;
    logic        rd_we;
  } mem_wb_t;

  // Byte-lane mask of an access at lane 0; shifted by the address offset.
  function automatic logic [3:0] lane_mask(lsu_width_e w);
    case (w)
      LSU_BYTE: lane_mask = 4'b0001;
      LSU_HALF: lane_mask = 4'b0011;
      default:  lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/panda_lsu.sv
// Load/store unit: request FSM, lane alignment, load extension, misalignment and stall.
module panda_lsu
  import panda_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic                   store_i,
  input  lsu_width_e             width_i,
  input  logic                   unsigned_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic                   data_req_o,
  input  logic                   data_gnt_i,
  output logic [AddrWidth-1:0]   data_addr_o,
  output logic                   data_we_o,
  output logic [DataWidth/8-1:0] data_be_o,
  output logic [DataWidth-1:0]   data_wdata_o,
  input  logic                   data_rvalid_i,
  input  logic [DataWidth-1:0]   data_rdata_i,
  output logic [DataWidth-1:0]   load_data_o,
  output logic                   misaligned_o,
  output logic                   stall_o,
  output lsu_state_e             state_o
);
  localparam int BeWidth = DataWidth / 8;

  lsu_state_e             state_q;
  logic [AddrWidth-1:0]   addr_q;
  logic                   we_q;
  logic [BeWidth-1:0]     be_q;
  logic [DataWidth-1:0]   wdata_q;
  logic [1:0]             off;
  logic                   misaligned;
  logic                   start;
  logic [AddrWidth-1:0]   addr_new;
  logic [BeWidth-1:0]     be_new;
  logic [DataWidth-1:0]   wdata_new;
  logic [7:0]             ld_byte;
  logic [15:0]            ld_half;

  assign off      = addr_i[1:0];
  assign addr_new = {addr_i[AddrWidth-1:2], 2'b00};
  assign be_new   = BeWidth'(lane_mask(width_i)) << off;

  always_comb begin
    misaligned = 1'b0;
    wdata_new  = wdata_i;
    case (width_i)
      LSU_BYTE: wdata_new = {4{wdata_i[7:0]}};
      LSU_HALF: begin
        misaligned = off[0];
        wdata_new  = {2{wdata_i[15:0]}};
      end
      default:  misaligned = (off != 2'b00);
    endcase
  end

  // Gated by rst_ni so no request escapes while the core is held in reset.
  assign start        = rst_ni && (state_q == LSU_IDLE) && (load_i || store_i) && !misaligned;
  assign misaligned_o = rst_ni && (state_q == LSU_IDLE) && (load_i || store_i) && misaligned;

  assign data_req_o   = start || (state_q == LSU_WAIT_GNT);
  assign data_addr_o  = start ? addr_new  : addr_q;
  assign data_we_o    = start ? store_i   : we_q;
  assign data_be_o    = start ? be_new    : be_q;
  assign data_wdata_o = start ? wdata_new : wdata_q;
  assign stall_o      = start || (state_q == LSU_WAIT_GNT) ||
                        ((state_q == LSU_WAIT_RVALID) && !data_rvalid_i);
  assign state_o      = state_q;

  // EX/MEM is frozen until the rvalid edge, so the live offset still belongs to this load.
  assign ld_byte = data_rdata_i[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

  always_comb begin
    load_data_o = data_rdata_i;
    case (width_i)
      LSU_BYTE: load_data_o = {{24{~unsigned_i & ld_byte[7]}}, ld_byte};
      LSU_HALF: load_data_o = {{16{~unsigned_i & ld_half[15]}}, ld_half};
      default:  load_data_o = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (start) begin
            addr_q  <= addr_new;
            we_q    <= store_i;
            be_q    <= be_new;
            wdata_q <= wdata_new;
            state_q <= data_gnt_i ? LSU_WAIT_RVALID : LSU_WAIT_GNT;
          end
        end
        LSU_WAIT_GNT:    if (data_gnt_i) state_q <= LSU_WAIT_RVALID;
        LSU_WAIT_RVALID: if (data_rvalid_i) state_q <= LSU_IDLE;
        default:         state_q <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/panda_mem_stage.sv
// Panda MEM stage: store-data forwarding, rd writeback select and the MEM/WB register.
// Handshake: a request is accepted on a cycle with data_req_o && data_gnt_i; exactly one data_rvalid_i follows, no earlier than the next cycle.
module panda_mem_stage
  import panda_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  ex_mem_t                ex_mem_i,
  output mem_wb_t                mem_wb_o,
  input  logic [4:0]             wb_rd_addr_i,
  input  logic [31:0]            wb_rd_data_i,
  input  logic                   wb_rd_we_i,
  output logic                   data_req_o,
  input  logic                   data_gnt_i,
  output logic [AddrWidth-1:0]   data_addr_o,
  output logic                   data_we_o,
  output logic [DataWidth/8-1:0] data_be_o,
  output logic [DataWidth-1:0]   data_wdata_o,
  input  logic                   data_rvalid_i,
  input  logic [DataWidth-1:0]   data_rdata_i,
  output logic                   stall_o,
  output logic                   lsu_misaligned_o
);
  lsu_state_e  lsu_state;
  logic        is_load;
  logic        fwd_hit;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic [31:0] rd_data;

  assign is_load = (ex_mem_i.rd_data_sel == RD_DATA_MEM) && ex_mem_i.rd_we;

  // WB only holds a real value in the first request cycle; afterwards it carries bubbles.
  assign fwd_hit    = (lsu_state == LSU_IDLE) && wb_rd_we_i &&
                      (wb_rd_addr_i == ex_mem_i.rs2_addr) && (ex_mem_i.rs2_addr != 5'd0);
  assign store_data = fwd_hit ? wb_rd_data_i : ex_mem_i.rs2_data;

  panda_lsu #(
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth)
  ) u_lsu (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (is_load),
    .store_i      (ex_mem_i.lsu_store),
    .width_i      (ex_mem_i.lsu_width),
    .unsigned_i   (ex_mem_i.lsu_load_unsigned),
    .addr_i       (ex_mem_i.alu_result[AddrWidth-1:0]),
    .wdata_i      (store_data),
    .data_req_o   (data_req_o),
    .data_gnt_i   (data_gnt_i),
    .data_addr_o  (data_addr_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_wdata_o (data_wdata_o),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i (data_rdata_i),
    .load_data_o  (load_data),
    .misaligned_o (lsu_misaligned_o),
    .stall_o      (stall_o),
    .state_o      (lsu_state)
  );

  always_comb begin
    rd_data = ex_mem_i.alu_result;
    case (ex_mem_i.rd_data_sel)
      RD_DATA_PC_INC: rd_data = ex_mem_i.pc_inc;
      RD_DATA_IMM:    rd_data = ex_mem_i.imm;
      RD_DATA_MEM:    rd_data = load_data;
      default:        rd_data = ex_mem_i.alu_result;
    endcase
  end

  // Stalls, misaligned accesses and completed stores all retire as bubbles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_wb_o <= '0;
    end else if (stall_o || lsu_misaligned_o || ex_mem_i.lsu_store) begin
      mem_wb_o <= '0;
    end else begin
      mem_wb_o.rd_data <= rd_data;
      mem_wb_o.rd_addr <= ex_mem_i.rd_addr;
      mem_wb_o.rd_we   <= ex_mem_i.rd_we;
    end
  end

endmodule

// File: tb/tb_panda_mem_stage.sv
// Bench for panda_mem_stage: directed vector table, random instructions against a lane-level model, reset sequences.
module tb_panda_mem_stage;
  import panda_pkg::*;

  logic        clk_i, rst_ni;
  ex_mem_t     ex_mem_i;
  mem_wb_t     mem_wb_o;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_rd_data_i;
  logic        wb_rd_we_i;
  logic        data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;
  logic        stall_o, lsu_misaligned_o;

  panda_mem_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ex_mem_i(ex_mem_i), .mem_wb_o(mem_wb_o),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i), .wb_rd_we_i(wb_rd_we_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .stall_o(stall_o), .lsu_misaligned_o(lsu_misaligned_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    ex_mem_t     e;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exp_req;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    logic        exp_rd_we;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  int          o_req_cnt, o_stall_cnt, o_mis_cnt;
  logic        o_stable, o_timeout, o_we;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_be;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic ex_mem_t op(rd_data_sel_e sel, logic rd_we, logic [4:0] rd, logic st,
                                 lsu_width_e w, logic uns, logic [31:0] alu,
                                 logic [4:0] rs2a, logic [31:0] rs2d);
    ex_mem_t e;
    e = '0;
    e.rd_data_sel = sel; e.rd_we = rd_we; e.rd_addr = rd; e.lsu_store = st;
    e.lsu_width = w; e.lsu_load_unsigned = uns; e.alu_result = alu;
    e.rs2_addr = rs2a; e.rs2_data = rs2d;
    e.pc_inc = alu + 32'd4; e.imm = 32'h0000_0A5A;
    return e;
  endfunction

  function automatic vec_t tv(ex_mem_t e, int g, int r, logic [31:0] rdata, logic wbwe,
                              logic [4:0] wba, logic [31:0] wbd, logic req, logic mis,
                              logic [3:0] be, logic [31:0] wdata, logic [31:0] rd, logic rdwe);
    vec_t v;
    v.e = e; v.gnt_dly = g; v.rv_dly = r; v.rdata = rdata;
    v.wb_we = wbwe; v.wb_addr = wba; v.wb_data = wbd;
    v.exp_req = req; v.exp_mis = mis; v.exp_be = be; v.exp_wdata = wdata;
    v.exp_rd = rd; v.exp_rd_we = rdwe;
    return v;
  endfunction

  // Reference model: byte-lane view of the access, built from sizes and offsets.
  function automatic vec_t model(vec_t v);
    int size, off;
    logic [31:0] sd, sh, mask, ld;
    logic is_load, acc;
    size = (v.e.lsu_width == LSU_BYTE) ? 1 : (v.e.lsu_width == LSU_HALF) ? 2 : 4;
    off  = int'(v.e.alu_result[1:0]);
    is_load = (v.e.rd_data_sel == RD_DATA_MEM) && v.e.rd_we;
    acc  = is_load || v.e.lsu_store;
    v.exp_mis = acc && ((off % size) != 0);
    v.exp_req = acc && !v.exp_mis;
    sd = (v.wb_we && v.wb_addr == v.e.rs2_addr && v.wb_addr != 0) ? v.wb_data : v.e.rs2_data;
    v.exp_be = '0; v.exp_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) v.exp_be[i] = 1'b1;
      v.exp_wdata[8*i +: 8] = sd[8*(i % size) +: 8];
    end
    sh   = v.rdata >> (8 * off);
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    ld   = sh & mask;
    if (!v.e.lsu_load_unsigned && size < 4 && sh[8*size-1]) ld = ld | ~mask;
    case (v.e.rd_data_sel)
      RD_DATA_ALU:    v.exp_rd = v.e.alu_result;
      RD_DATA_PC_INC: v.exp_rd = v.e.pc_inc;
      RD_DATA_IMM:    v.exp_rd = v.e.imm;
      default:        v.exp_rd = ld;
    endcase
    v.exp_rd_we = !v.exp_mis && !v.e.lsu_store && v.e.rd_we;
    return v;
  endfunction

  // Driver + memory responder: called just after a falling edge, returns on a falling edge.
  task automatic run_instr(input vec_t v, input int idx);
    int cyc, since;
    bit granted, done, c_req, c_stall;
    ex_mem_i = v.e; wb_rd_we_i = v.wb_we; wb_rd_addr_i = v.wb_addr; wb_rd_data_i = v.wb_data;
    data_rdata_i = v.rdata;
    o_req_cnt = 0; o_stall_cnt = 0; o_mis_cnt = 0; o_stable = 1'b1; o_timeout = 1'b0;
    granted = 0; done = 0; since = 0; cyc = 0;
    while (!done) begin
      data_rvalid_i = granted && (since == v.rv_dly);
      data_gnt_i    = 1'b0;
      #1;
      c_req = data_req_o; c_stall = stall_o;
      if (lsu_misaligned_o) o_mis_cnt++;
      if (c_req) begin
        if (o_req_cnt == 0) begin
          o_addr = data_addr_o; o_we = data_we_o; o_be = data_be_o; o_wdata = data_wdata_o;
        end else if (o_addr !== data_addr_o || o_we !== data_we_o ||
                     o_be !== data_be_o || o_wdata !== data_wdata_o) begin
          o_stable = 1'b0;
        end
        if (o_req_cnt == v.gnt_dly) data_gnt_i = 1'b1;
        o_req_cnt++;
      end
      if (c_stall) o_stall_cnt++;
      done = data_rvalid_i || (!c_req && !c_stall && !granted);
      if (data_gnt_i) begin granted = 1; since = 0; end
      @(posedge clk_i); #1;
      if (c_stall) begin
        chk("stall_bubble_we", idx, 32'(mem_wb_o.rd_we), 32'd0);
        chk("stall_bubble_data", idx, mem_wb_o.rd_data | 32'(mem_wb_o.rd_addr), 32'd0);
      end
      since++;
      // WB now holds unrelated values; a store must keep what it sampled first.
      wb_rd_we_i = 1'b1; wb_rd_addr_i = v.e.rs2_addr; wb_rd_data_i = ~(v.wb_data ^ v.e.rs2_data);
      @(negedge clk_i);
      cyc++;
      if (!done && cyc >= 40) begin o_timeout = 1'b1; done = 1; end
    end
    data_rvalid_i = 1'b0; data_gnt_i = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    run_instr(v, idx);
    chk("timeout", idx, 32'(o_timeout), 32'd0);
    chk("req_cycles", idx, 32'(o_req_cnt), v.exp_req ? 32'(v.gnt_dly + 1) : 32'd0);
    chk("stall_cycles", idx, 32'(o_stall_cnt), v.exp_req ? 32'(v.gnt_dly + v.rv_dly) : 32'd0);
    chk("misaligned_cycles", idx, 32'(o_mis_cnt), 32'(v.exp_mis));
    if (v.exp_req) begin
      chk("addr", idx, o_addr, {v.e.alu_result[31:2], 2'b00});
      chk("we", idx, 32'(o_we), 32'(v.e.lsu_store));
      chk("be", idx, 32'(o_be), 32'(v.exp_be));
      chk("req_stable", idx, 32'(o_stable), 32'd1);
      if (v.e.lsu_store) chk("wdata", idx, o_wdata, v.exp_wdata);
    end
    chk("rd_we", idx, 32'(mem_wb_o.rd_we), 32'(v.exp_rd_we));
    if (v.exp_rd_we) begin
      chk("rd_data", idx, mem_wb_o.rd_data, v.exp_rd);
      chk("rd_addr", idx, 32'(mem_wb_o.rd_addr), 32'(v.e.rd_addr));
    end
  endtask

  initial begin
    vec_t v;
    int kind;
    rst_ni = 1'b0; ex_mem_i = '0; data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;
    wb_rd_we_i = 0; wb_rd_addr_i = '0; wb_rd_data_i = '0;
    repeat (3) @(negedge clk_i);
    chk("reset_req", 0, 32'(data_req_o), 32'd0);
    chk("reset_stall", 0, 32'(stall_o), 32'd0);
    chk("reset_mem_wb", 0, mem_wb_o.rd_data | 32'(mem_wb_o.rd_addr) | 32'(mem_wb_o.rd_we), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // directed vectors
    tbl.push_back(tv(op(RD_DATA_MEM, 1, 5'd1, 0, LSU_WORD, 0, 32'h100, 0, 0), 0, 1, 32'hDEADBEEF,
                     0, 0, 0, 1, 0, 4'hF, 0, 32'hDEADBEEF, 1));
    tbl.push_back(tv(op(RD_DATA_MEM, 1, 5'd2, 0, LSU_BYTE, 0, 32'h103, 0, 0), 0, 1, 32'h80FFFFFF,
                     0, 0, 0, 1, 0, 4'h8, 0, 32'hFFFFFF80, 1));
    tbl.push_back(tv(op(RD_DATA_MEM, 1, 5'd2, 0, LSU_BYTE, 1, 32'h103, 0, 0), 0, 1, 32'h80FFFFFF,
                     0, 0, 0, 1, 0, 4'h8, 0, 32'h00000080, 1));
    tbl.push_back(tv(op(RD_DATA_ALU, 0, 5'd0, 1, LSU_HALF, 0, 32'h102, 5'd3, 32'h0000ABCD), 3, 1, 0,
                     0, 0, 0, 1, 0, 4'hC, 32'hABCDABCD, 0, 0));
    tbl.push_back(tv(op(RD_DATA_ALU, 0, 5'd0, 1, LSU_WORD, 0, 32'h200, 5'd5, 32'hCAFE0000), 0, 1, 0,
                     1, 5'd5, 32'h12345678, 1, 0, 4'hF, 32'h12345678, 0, 0));
    tbl.push_back(tv(op(RD_DATA_ALU, 0, 5'd0, 1, LSU_WORD, 0, 32'h204, 5'd0, 32'h0BADF00D), 0, 1, 0,
                     1, 5'd0, 32'h12345678, 1, 0, 4'hF, 32'h0BADF00D, 0, 0));
    tbl.push_back(tv(op(RD_DATA_MEM, 1, 5'd3, 0, LSU_HALF, 0, 32'h101, 0, 0), 0, 1, 32'h11112222,
                     0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(tv(op(RD_DATA_ALU, 1, 5'd7, 0, LSU_WORD, 0, 32'h55AA, 0, 0), 0, 1, 0,
                     0, 0, 0, 0, 0, 0, 0, 32'h55AA, 1));
    tbl.push_back(tv(op(RD_DATA_MEM, 1, 5'd8, 0, LSU_HALF, 1, 32'h102, 0, 0), 1, 2, 32'h80011234,
                     0, 0, 0, 1, 0, 4'hC, 0, 32'h00008001, 1));
    tbl.push_back(tv(op(RD_DATA_MEM, 1, 5'd8, 0, LSU_HALF, 0, 32'h102, 0, 0), 0, 1, 32'h80011234,
                     0, 0, 0, 1, 0, 4'hC, 0, 32'hFFFF8001, 1));
    tbl.push_back(tv(op(RD_DATA_ALU, 0, 5'd0, 1, LSU_BYTE, 0, 32'h101, 5'd4, 32'h123456EF), 0, 3, 0,
                     0, 0, 0, 1, 0, 4'h2, 32'hEFEFEFEF, 0, 0));
    tbl.push_back(tv(op(RD_DATA_IMM, 1, 5'd9, 0, LSU_WORD, 0, 32'h40, 0, 0), 0, 1, 0,
                     0, 0, 0, 0, 0, 0, 0, 32'h00000A5A, 1));
    tbl.push_back(tv(op(RD_DATA_PC_INC, 1, 5'd1, 0, LSU_WORD, 0, 32'h1000, 0, 0), 0, 1, 0,
                     0, 0, 0, 0, 0, 0, 0, 32'h00001004, 1));
    tbl.push_back(tv(op(RD_DATA_ALU, 0, 5'd0, 1, LSU_WORD, 0, 32'h102, 5'd6, 32'h1), 0, 1, 0,
                     0, 0, 0, 0, 1, 0, 0, 0, 0));
    foreach (tbl[i]) check_vec(tbl[i], i);

    // random instructions against the model
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 2);
      v.gnt_dly = $urandom_range(0, 3); v.rv_dly = $urandom_range(1, 3);
      v.rdata = $urandom(); v.wb_data = $urandom(); v.wb_we = 1'($urandom_range(0, 1));
      v.e = op(rd_data_sel_e'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), 0, lsu_width_e'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)), $urandom(), 5'($urandom_range(0, 31)), $urandom());
      v.e.imm = $urandom();
      v.wb_addr = ($urandom_range(0, 1) == 1) ? v.e.rs2_addr : 5'($urandom_range(0, 31));
      if (kind == 0) begin
        v.e.rd_data_sel = RD_DATA_MEM; v.e.rd_we = 1'b1;
      end else if (kind == 1) begin
        v.e.lsu_store = 1'b1; v.e.rd_we = 1'b0;
      end
      check_vec(model(v), 100 + n);
    end

    // reset with a retired result in MEM/WB
    check_vec(tv(op(RD_DATA_ALU, 1, 5'd4, 0, LSU_WORD, 0, 32'h77, 0, 0), 0, 1, 0,
                 0, 0, 0, 0, 0, 0, 0, 32'h77, 1), 200);
    rst_ni = 1'b0; #1;
    chk("reset_clears_mem_wb", 201, mem_wb_o.rd_data | 32'(mem_wb_o.rd_addr) | 32'(mem_wb_o.rd_we), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;

    // reset while waiting for rvalid
    ex_mem_i = op(RD_DATA_MEM, 1, 5'd6, 0, LSU_WORD, 0, 32'h300, 0, 0);
    wb_rd_we_i = 0; #1;
    chk("mid_req_issue", 202, 32'(data_req_o), 32'd1);
    data_gnt_i = 1'b1;
    @(posedge clk_i); #1; data_gnt_i = 1'b0;
    chk("mid_wait_stall", 203, 32'(stall_o), 32'd1);
    chk("mid_wait_req", 204, 32'(data_req_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b0; #1;
    chk("mid_reset_stall", 205, 32'(stall_o), 32'd0);
    chk("mid_reset_req", 206, 32'(data_req_o), 32'd0);
    chk("mid_reset_addr", 207, data_addr_o, 32'd0);
    chk("mid_reset_be", 208, 32'(data_be_o), 32'd0);
    chk("mid_reset_mem_wb", 209, mem_wb_o.rd_data | 32'(mem_wb_o.rd_addr) | 32'(mem_wb_o.rd_we), 32'd0);
    ex_mem_i = '0;
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    check_vec(tv(op(RD_DATA_ALU, 1, 5'd11, 0, LSU_WORD, 0, 32'hA5A5_0001, 0, 0), 0, 1, 0,
                 0, 0, 0, 0, 0, 0, 0, 32'hA5A5_0001, 1), 210);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
